// File: rtl/note_player.sv
// note_player -- UART-fed note sequencer driving a square-wave buzzer.
//
// Received bytes are queued in a small FIFO. Each byte is one note:
//   [3:0] note (0 = rest, 1..7 = C..B)
//   [5:4] octave (0 = low, 1 = mid, 2 = high)
//   [7:6] duration code d, lasting (1 << d) * BEAT_TICKS cycles.
// Byte 0xFF flushes the queue and silences the output at once. Bytes with
// note 8..15 or octave 3 are discarded.
//
// Optional feature: define NOTE_PLAYER_GAP_EN to insert GAP_TICKS silent
// cycles after every note.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset, release synchronised inside
//   rx_ack    in   one-cycle strobe, bdata holds a valid byte
//   bdata     in   received byte
//   buzzer    out  square-wave tone
//   playing   out  high while a note (or rest) is being played
//   cur_note  out  note index being played, 0 otherwise
//   fifo_cnt  out  queue occupancy
//   fifo_full out  queue holds FIFO_DEPTH bytes
//   overflow  out  sticky: a valid byte was dropped on a full queue
module note_player #(
    parameter int FIFO_DEPTH     = 8,
    parameter int BEAT_TICKS     = 12500000,
    parameter int TONE_DIV_SHIFT = 0,
    parameter int GAP_TICKS      = 1250000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_ack,
    input  logic [7:0]                  bdata,
    output logic                        buzzer,
    output logic                        playing,
    output logic [3:0]                  cur_note,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        fifo_full,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // One tick counter times both the note and the silent gap.
    localparam int CNT_MAX = (8 * BEAT_TICKS > GAP_TICKS) ? 8 * BEAT_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [AW:0] DEPTH_V = AW'(0) + (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

`ifdef NOTE_PLAYER_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;
`endif

    // Tone half-period in clk cycles for a note/octave pair.
    function automatic logic [20:0] half_period(input logic [3:0] note, input logic [1:0] oct);
        logic [20:0] mid;
        logic [20:0] scaled;
        case (note)
            4'd1:    mid = 21'd191110;
            4'd2:    mid = 21'd170265;
            4'd3:    mid = 21'd151685;
            4'd4:    mid = 21'd143172;
            4'd5:    mid = 21'd127551;
            4'd6:    mid = 21'd113636;
            4'd7:    mid = 21'd101239;
            default: mid = 21'd0;
        endcase
        case (oct)
            2'd0:    scaled = mid << 1;
            2'd2:    scaled = mid >> 1;
            default: scaled = mid;
        endcase
        return scaled >> TONE_DIV_SHIFT;
    endfunction

    // Note length in clk cycles for duration code d.
    function automatic logic [CNT_W-1:0] note_ticks(input logic [1:0] d);
        return CNT_W'(BEAT_TICKS) << d;
    endfunction

    state_t             state;
    logic               rst_sync_p0;
    logic               rst_sync_p1;
    logic               run;
    logic               flush;
    logic               byte_ok;
    logic               push;
    logic               pop;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [7:0]         head;
    logic [20:0]        half_r;
    logic [CNT_W-1:0]   dur_r;
    logic [3:0]         note_r;
    logic [CNT_W-1:0]   tick_cnt;
    logic [20:0]        hp_cnt;

    // Reset release synchroniser: nothing acts until two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    assign run       = rst_sync_p1;
    assign flush     = run & rx_ack & (bdata == 8'hFF);
    assign byte_ok   = run & rx_ack & ~flush & ~bdata[3] & (bdata[5:4] != 2'd3);
    assign fifo_full = (fifo_cnt == DEPTH_V);
    assign push      = byte_ok & ~fifo_full;
    assign pop       = (state == S_LOAD) & ~flush;
    assign head      = mem[rd_ptr];

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bdata;
        end
    end

    // Queue control; a full queue drops the byte even if LOAD pops this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (byte_ok && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Note parameters captured from the queue head during LOAD
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            half_r <= half_period(head[3:0], head[5:4]);
            dur_r  <= note_ticks(head[7:6]);
            note_r <= head[3:0];
        end
    end

    // Sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            buzzer   <= 1'b0;
            tick_cnt <= '0;
            hp_cnt   <= '0;
        end else if (flush) begin
            state    <= S_IDLE;
            buzzer   <= 1'b0;
            tick_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_cnt != '0) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state    <= S_PLAY;
                    buzzer   <= 1'b0;
                    tick_cnt <= '0;
                    hp_cnt   <= '0;
                end
                S_PLAY: begin
                    if (tick_cnt == dur_r - CNT_W'(1)) begin
                        buzzer   <= 1'b0;
                        tick_cnt <= '0;
`ifdef NOTE_PLAYER_GAP_EN
                        state    <= S_GAP;
`else
                        state    <= (fifo_cnt != '0) ? S_LOAD : S_IDLE;
`endif
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                        // Rests keep the buzzer low; a half-period of 0 or 1 toggles every cycle.
                        if (note_r != 4'd0) begin
                            if (hp_cnt + 21'd1 >= half_r) begin
                                buzzer <= ~buzzer;
                                hp_cnt <= '0;
                            end else begin
                                hp_cnt <= hp_cnt + 21'd1;
                            end
                        end
                    end
                end
`ifdef NOTE_PLAYER_GAP_EN
                S_GAP: begin
                    if (tick_cnt == CNT_W'(GAP_TICKS - 1)) begin
                        tick_cnt <= '0;
                        state    <= (fifo_cnt != '0) ? S_LOAD : S_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign playing  = (state == S_PLAY);
    assign cur_note = playing ? note_r : 4'd0;

endmodule
